// File: rtl/rv32i_fetch.sv
// rv32i_fetch
// Instruction fetch stage of a multicycle RV32I core. Owns the program
// counter, issues a single instruction-memory read at a time and holds the
// returned word for decode until decode accepts it. PC redirects from branch
// resolution are honoured at any time; a response that belongs to a request
// made before the redirect is discarded.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   o_imem_req_valid/o_imem_addr read request (valid/ready with i_imem_req_ready)
//   i_imem_rsp_valid/_data/_error read response (valid only, no backpressure)
//   o_fetch_valid/_instruction/_pc/_fault  held entry for decode
//   i_decode_ready               decode consumes the held entry
//   i_redirect_valid/_pc         redirect target from branch resolution
//   o_fetch_count                completed decode handshakes (wraps)
//
// state | meaning
// ------+----------------------------------------------------------------
// REQ   | presenting a read at pc (or detecting a misaligned pc)
// WAIT  | request accepted, waiting for its response
// DROP  | request accepted but redirected; swallow its response
// HOLD  | entry presented to decode until handshake or redirect
module rv32i_fetch #(
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter int                           WORD_SIZE         = 32,
    parameter logic [WORD_SIZE-1:0]         RESET_PC          = 32'h0000_0000,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = 32'h0000_0013
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic                         o_imem_req_valid,
    input  logic                         i_imem_req_ready,
    output logic [WORD_SIZE-1:0]         o_imem_addr,
    input  logic                         i_imem_rsp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rsp_data,
    input  logic                         i_imem_rsp_error,
    output logic                         o_fetch_valid,
    input  logic                         i_decode_ready,
    output logic [INSTRUCTION_WIDTH-1:0] o_fetch_instruction,
    output logic [WORD_SIZE-1:0]         o_fetch_pc,
    output logic                         o_fetch_fault,
    input  logic                         i_redirect_valid,
    input  logic [WORD_SIZE-1:0]         i_redirect_pc,
    output logic [31:0]                  o_fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                         state, state_nxt;
    logic [WORD_SIZE-1:0]           pc, pc_nxt;
    logic [INSTRUCTION_WIDTH-1:0]   instr, instr_nxt;
    logic [WORD_SIZE-1:0]           fetch_pc, fetch_pc_nxt;
    logic                           fault, fault_nxt;
    logic [31:0]                    count, count_nxt;
    logic                           misaligned;

    assign misaligned = (pc[1:0] != 2'b00);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            instr    <= '0;
            fetch_pc <= '0;
            fault    <= 1'b0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            instr    <= instr_nxt;
            fetch_pc <= fetch_pc_nxt;
            fault    <= fault_nxt;
            count    <= count_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_nxt    = instr;
        fetch_pc_nxt = fetch_pc;
        fault_nxt    = fault;
        count_nxt    = count;

        case (state)
            S_REQ: begin
                if (misaligned) begin
                    // A misaligned pc never reaches the bus; it becomes a
                    // fault entry that decode must still consume.
                    state_nxt    = S_HOLD;
                    instr_nxt    = NOP_INSTR;
                    fetch_pc_nxt = pc;
                    fault_nxt    = 1'b1;
                end else begin
                    if (i_imem_req_ready) begin
                        state_nxt = i_redirect_valid ? S_DROP : S_WAIT;
                    end
                    if (i_redirect_valid) begin
                        pc_nxt = i_redirect_pc;
                    end
                end
            end
            S_WAIT: begin
                if (i_redirect_valid) begin
                    pc_nxt    = i_redirect_pc;
                    // Response in the same cycle is simply dropped; otherwise
                    // it is still outstanding and must be swallowed in DROP.
                    state_nxt = i_imem_rsp_valid ? S_REQ : S_DROP;
                end else if (i_imem_rsp_valid) begin
                    state_nxt    = S_HOLD;
                    instr_nxt    = i_imem_rsp_error ? NOP_INSTR : i_imem_rsp_data;
                    fetch_pc_nxt = pc;
                    fault_nxt    = i_imem_rsp_error;
                end
            end
            S_DROP: begin
                if (i_redirect_valid) begin
                    pc_nxt = i_redirect_pc;
                end
                if (i_imem_rsp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (i_decode_ready) begin
                    count_nxt = count + 32'd1;
                    pc_nxt    = pc + WORD_SIZE'(4);
                    state_nxt = S_REQ;
                end
                if (i_redirect_valid) begin
                    pc_nxt    = i_redirect_pc;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    assign o_imem_req_valid    = (state == S_REQ) && !misaligned;
    assign o_imem_addr         = pc;
    assign o_fetch_valid       = (state == S_HOLD);
    assign o_fetch_instruction = instr;
    assign o_fetch_pc          = fetch_pc;
    assign o_fetch_fault       = fault;
    assign o_fetch_count       = count;

endmodule

// File: tb/tb_rv32i_fetch.sv
module tb_rv32i_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] imem_addr;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_data;
    logic        fetch_valid, decode_ready, fetch_fault;
    logic [31:0] fetch_instr, fetch_pc, fetch_count;
    logic        redir_valid;
    logic [31:0] redir_pc;

    always #5 clk = ~clk;

    rv32i_fetch dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .o_imem_req_valid    (req_valid),
        .i_imem_req_ready    (req_ready),
        .o_imem_addr         (imem_addr),
        .i_imem_rsp_valid    (rsp_valid),
        .i_imem_rsp_data     (rsp_data),
        .i_imem_rsp_error    (rsp_error),
        .o_fetch_valid       (fetch_valid),
        .i_decode_ready      (decode_ready),
        .o_fetch_instruction (fetch_instr),
        .o_fetch_pc          (fetch_pc),
        .o_fetch_fault       (fetch_fault),
        .i_redirect_valid    (redir_valid),
        .i_redirect_pc       (redir_pc),
        .o_fetch_count       (fetch_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: a pc, whether a read is outstanding, whether
    // that read has been made stale by a redirect, and the entry held for decode.
    logic [31:0] m_pc, m_instr, m_fpc, m_count;
    logic        m_fault, m_held, m_out, m_stale;
    logic        accepted;

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = 0; m_fpc = 0; m_count = 0;
        m_fault = 0; m_held = 0; m_out = 0; m_stale = 0;
    endtask

    task automatic idle();
        rst = 0; req_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_error = 0;
        decode_ready = 0; redir_valid = 0; redir_pc = 0;
    endtask

    // Called at a falling edge with inputs already driven: check, advance
    // the model, then step one clock.
    task automatic cyc();
        logic exp_req;
        #1;
        exp_req = !m_held && !m_out && (m_pc[1:0] == 2'b00);
        chk("req_valid", {31'd0, req_valid}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_held});
        chk("fetch_instr", fetch_instr, m_instr);
        chk("fetch_pc", fetch_pc, m_fpc);
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        chk("fetch_count", fetch_count, m_count);
        accepted = req_valid && req_ready && !rst;

        if (rst) begin
            model_reset();
        end else if (m_held) begin
            if (decode_ready) m_count = m_count + 1;
            if (redir_valid) m_pc = redir_pc;
            else if (decode_ready) m_pc = m_pc + 4;
            if (decode_ready || redir_valid) m_held = 0;
        end else if (!m_out) begin
            if (m_pc[1:0] != 2'b00) begin
                m_held = 1; m_instr = NOP_INSTR; m_fpc = m_pc; m_fault = 1;
            end else begin
                if (req_ready) begin m_out = 1; m_stale = redir_valid; end
                if (redir_valid) m_pc = redir_pc;
            end
        end else begin
            if (rsp_valid) begin
                m_out = 0;
                if (m_stale || redir_valid) begin
                    if (redir_valid) m_pc = redir_pc;
                end else begin
                    m_held = 1;
                    m_instr = rsp_error ? NOP_INSTR : rsp_data;
                    m_fpc = m_pc;
                    m_fault = rsp_error;
                end
            end else if (redir_valid) begin
                m_stale = 1; m_pc = redir_pc;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Random memory: one pending read with a 1..3 cycle response latency.
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_data;
    logic        mem_err;

    initial begin
        idle();
        rst = 1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_instr", fetch_instr, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        rst = 0;

        // Basic fetch at address 0, then advance to 4.
        idle(); req_ready = 1; cyc();
        idle(); rsp_valid = 1; rsp_data = 32'h0050_0093; cyc();
        chk("t1_valid", {31'd0, fetch_valid}, 32'd1);
        chk("t1_instr", fetch_instr, 32'h0050_0093);
        idle(); decode_ready = 1; cyc();
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_count", fetch_count, 32'd1);

        // Decode stalls in HOLD for 5 cycles.
        idle(); req_ready = 1; cyc();
        idle(); rsp_valid = 1; rsp_data = 32'h1234_5678; cyc();
        for (int i = 0; i < 5; i++) begin idle(); cyc(); end
        chk("t2_stall_pc", fetch_pc, 32'h4);
        idle(); decode_ready = 1; cyc();

        // Redirect in WAIT: stale response discarded.
        idle(); req_ready = 1; cyc();
        idle(); redir_valid = 1; redir_pc = 32'h100; cyc();
        idle(); rsp_valid = 1; rsp_data = 32'hDEAD_BEEF; cyc();
        chk("t3_no_stale", {31'd0, fetch_valid}, 32'd0);
        chk("t3_addr", imem_addr, 32'h100);
        idle(); req_ready = 1; cyc();
        idle(); rsp_valid = 1; rsp_data = 32'h0000_0073; cyc();
        chk("t3_fpc", fetch_pc, 32'h100);
        idle(); decode_ready = 1; cyc();

        // Redirect coincident with rsp in WAIT, then with request acceptance.
        idle(); req_ready = 1; cyc();
        idle(); rsp_valid = 1; rsp_data = 32'hBAD0_0000; redir_valid = 1; redir_pc = 32'h200; cyc();
        chk("t4_addr", imem_addr, 32'h200);
        idle(); req_ready = 1; redir_valid = 1; redir_pc = 32'h300; cyc();
        idle(); cyc();
        idle(); rsp_valid = 1; rsp_data = 32'hBAD0_0001; cyc();
        chk("t4_drop_addr", imem_addr, 32'h300);
        idle(); req_ready = 1; cyc();
        idle(); rsp_valid = 1; rsp_data = 32'h0000_1111; cyc();
        idle(); decode_ready = 1; cyc();

        // Misaligned redirect produces a fault entry without a request.
        idle(); redir_valid = 1; redir_pc = 32'h102; cyc();
        idle(); cyc();
        chk("t5_fault", {31'd0, fetch_fault}, 32'd1);
        chk("t5_instr", fetch_instr, NOP_INSTR);
        chk("t5_fpc", fetch_pc, 32'h102);
        idle(); decode_ready = 1; redir_valid = 1; redir_pc = 32'h400; cyc();
        idle(); req_ready = 1; cyc();
        idle(); rsp_valid = 1; rsp_error = 1; rsp_data = 32'hFFFF_FFFF; cyc();
        chk("t5_err_fault", {31'd0, fetch_fault}, 32'd1);
        chk("t5_err_instr", fetch_instr, NOP_INSTR);
        idle(); decode_ready = 1; cyc();

        // Reset while in WAIT; late response ignored.
        idle(); req_ready = 1; cyc();
        idle(); rst = 1; cyc();
        idle(); rsp_valid = 1; rsp_data = 32'hDEAD_BEEF; cyc();
        chk("t6_addr", imem_addr, RESET_PC);
        chk("t6_count", fetch_count, 32'd0);
        chk("t6_valid", {31'd0, fetch_valid}, 32'd0);

        // Randomized traffic.
        mem_pend = 0; mem_cnt = 0; mem_data = 0; mem_err = 0;
        for (int n = 0; n < 4000; n++) begin
            idle();
            req_ready    = ($urandom_range(3) != 0);
            decode_ready = ($urandom_range(1) != 0);
            if ($urandom_range(9) == 0) begin
                redir_valid = 1;
                redir_pc = ($urandom_range(511) << 2) | (($urandom_range(7) == 0) ? 32'd2 : 32'd0);
            end
            if (mem_pend && mem_cnt == 0) begin
                rsp_valid = 1; rsp_data = mem_data; rsp_error = mem_err;
            end else if (!mem_pend && $urandom_range(15) == 0) begin
                rsp_valid = 1; rsp_data = $urandom;
            end
            cyc();
            if (mem_pend) begin
                if (mem_cnt == 0) mem_pend = 0;
                else mem_cnt--;
            end
            if (accepted) begin
                mem_pend = 1;
                mem_cnt  = $urandom_range(2);
                mem_data = $urandom;
                mem_err  = ($urandom_range(7) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
